// File: rtl/cx_stream_arb_pkg.sv
// Shared types and helpers for the CX DMA stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cx_stream_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Output buffer depth and the width needed to count 0..depth.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // Widest request vector rr_pick can scan.
    localparam int RR_MAX_SRC = 16;

    // Round-robin pick: first asserted request at or after ptr, wrapping
    // modulo n. Returns ptr unchanged when no request is asserted.
    function automatic logic [3:0] rr_pick(
        input logic [RR_MAX_SRC-1:0] req,
        input logic [3:0]            ptr,
        input int                    n
    );
        logic [3:0] pick;
        logic [4:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_SRC; k++) begin
            // ptr < n and k < n, so one subtraction is enough to wrap.
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= 5'(n)) begin
                idx = idx - 5'(n);
            end
            if (!found && (k < n) && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cx_stream_skid.sv
// Generic small FIFO used as the arbiter's output buffer (push/pop, count).
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees a slot; caller watches count.
//
// Ports: clk/rstn (async active-low), push/push_dat write side,
//        pop/head_dat read side (head is zero when empty), count = occupancy.
module cx_stream_skid
    import cx_stream_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_dat,
    output logic [SKID_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != SKID_CNT_W'(SKID_DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Empty head reads as zero so idle output fields are clean.
    assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cx_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one CX DMA stream among NUM_SRC masters.
// Latency: request -> s_tready 1 cycle; accepted beat -> m_tvalid 1 cycle; one bubble between grants.
// Backpressure: granted s_tready follows output-buffer room (count < 2); m_tready only pops the buffer.
//
// Ports: clk, rstn (async active-low);
//        s_tvalid/s_tready/s_tlast per source, s_tdata/s_tstrb/s_tid packed by source index;
//        m_tvalid/m_tready/m_tlast/m_tdata/m_tstrb/m_tid outbound stream;
//        grant_valid/grant_idx current owner; err_overlong pulses on a watchdog release.
module cx_stream_arbiter
    import cx_stream_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int TAG_SRC    = 0,
    parameter int MAX_BEATS  = 256
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_SRC-1:0]             s_tvalid,
    output logic [NUM_SRC-1:0]             s_tready,
    input  logic [NUM_SRC-1:0]             s_tlast,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    s_tid,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic [DATA_WIDTH/8-1:0]        m_tstrb,
    output logic [ID_WIDTH-1:0]            m_tid,
    output logic                           grant_valid,
    output logic [$clog2(NUM_SRC)-1:0]     grant_idx,
    output logic                           err_overlong
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
        logic [ID_WIDTH-1:0]   id;
    } beat_t;

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      next_ptr;
    logic [CNT_W-1:0]      beat_cnt;
    logic [SKID_CNT_W-1:0] buf_count;
    logic                  buf_room;
    logic                  any_req;
    logic                  accept;
    logic                  wd_hit;
    logic                  release_grant;
    logic                  pop;
    beat_t                 push_beat;
    beat_t                 head_beat;

    // Unpack the per-source buses so the granted source can be indexed directly.
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [STRB_W-1:0]     src_strb [NUM_SRC];
    logic [ID_WIDTH-1:0]   src_id   [NUM_SRC];
    logic [ID_WIDTH-1:0]   tagged_id;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_strb[i] = s_tstrb[i*STRB_W +: STRB_W];
        assign src_id[i]   = s_tid[i*ID_WIDTH +: ID_WIDTH];
    end

    // Low tid bits carry the source index when tagging is enabled.
    if (TAG_SRC != 0) begin : g_tag
        if (ID_WIDTH > IDX_W) begin : g_keep_upper
            assign tagged_id = {src_id[grant_idx][ID_WIDTH-1:IDX_W], grant_idx};
        end else begin : g_idx_only
            assign tagged_id = ID_WIDTH'(grant_idx);
        end
    end else begin : g_pass
        assign tagged_id = src_id[grant_idx];
    end

    assign buf_room = buf_count < SKID_CNT_W'(SKID_DEPTH);
    assign any_req  = |s_tvalid;
    assign pick_idx = IDX_W'(rr_pick(RR_MAX_SRC'(s_tvalid), 4'(rr_ptr), NUM_SRC));
    assign next_ptr = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

    assign accept = (state == ARB_LOCKED) && s_tvalid[grant_idx] && buf_room;
    assign wd_hit = (MAX_BEATS != 0) && (beat_cnt == LAST_BEAT);

    // A watchdog hit closes the packet on the way out so downstream sees a
    // well-formed (if truncated) packet.
    assign push_beat.last = s_tlast[grant_idx] | wd_hit;
    assign push_beat.data = src_data[grant_idx];
    assign push_beat.strb = src_strb[grant_idx];
    assign push_beat.id   = tagged_id;

    assign release_grant = accept && push_beat.last;

    always_comb begin
        s_tready = '0;
        if ((state == ARB_LOCKED) && buf_room) begin
            s_tready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            beat_cnt     <= '0;
            err_overlong <= 1'b0;
        end else begin
            err_overlong <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_req && buf_room) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    // The grant is kept through source-side tvalid gaps.
                    if (accept) begin
                        if (release_grant) begin
                            state        <= ARB_IDLE;
                            grant_valid  <= 1'b0;
                            rr_ptr       <= next_ptr;
                            err_overlong <= wd_hit && !s_tlast[grant_idx];
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign pop = m_tvalid && m_tready;

    cx_stream_skid #(
        .WIDTH ($bits(beat_t))
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .push     (accept),
        .push_dat (push_beat),
        .pop      (pop),
        .head_dat (head_beat),
        .count    (buf_count)
    );

    assign m_tvalid = buf_count != '0;
    assign m_tlast  = head_beat.last;
    assign m_tdata  = head_beat.data;
    assign m_tstrb  = head_beat.strb;
    assign m_tid    = head_beat.id;

endmodule

// File: tb/tb_cx_stream_arbiter.sv
module tb_cx_stream_arbiter;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int IW   = 8;
    localparam int MAXB = 4;
    localparam int SCAP = 128;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [NS-1:0]     s_tvalid = '0;
    logic [NS-1:0]     s_tready;
    logic [NS-1:0]     s_tlast = '0;
    logic [NS*DW-1:0]  s_tdata = '0;
    logic [NS*SW-1:0]  s_tstrb = '0;
    logic [NS*IW-1:0]  s_tid = '0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [IW-1:0]     m_tid;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic              err_overlong;

    cx_stream_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_SRC(1), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tid(s_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tid(m_tid),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .err_overlong(err_overlong)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- source-side stimulus storage ----------------
    logic [DW-1:0] sd  [NS][SCAP];
    logic          sl  [NS][SCAP];
    logic [IW-1:0] sid [NS][SCAP];
    int            slen [NS];
    int            spos [NS];
    logic [NS-1:0] hs = '0;
    int            vprob = 100;
    int            mt_mode = 1;   // 0/1 fixed level, 2 random

    task automatic add_pkt(input int src, input int n, input logic [IW-1:0] tid, input logic [DW-1:0] base);
        for (int b = 0; b < n; b++) begin
            if (slen[src] < SCAP) begin
                sd[src][slen[src]]  = base + DW'(b);
                sl[src][slen[src]]  = (b == n - 1);
                sid[src][slen[src]] = tid;
                slen[src]++;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            slen[i] = 0;
            spos[i] = 0;
        end
        s_tvalid = '0;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) spos[i]++;
            if (spos[i] >= slen[i]) begin
                spos[i] = 0;
                slen[i] = 0;
                s_tvalid[i] = 1'b0;
            end else begin
                if (!s_tvalid[i] || hs[i]) s_tvalid[i] = ($urandom_range(99) < vprob);
                s_tlast[i]          = sl[i][spos[i]];
                s_tdata[i*DW +: DW] = sd[i][spos[i]];
                s_tstrb[i*SW +: SW] = sd[i][spos[i]][SW-1:0];
                s_tid[i*IW +: IW]   = sid[i][spos[i]];
            end
        end
        if (mt_mode == 2) m_tready = 1'($urandom_range(1));
        else              m_tready = (mt_mode != 0);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [IW-1:0] id;
    } mbeat_t;

    mbeat_t mq[$];          // contents of the output buffer, head first
    bit     m_locked = 0;
    int     m_g = 0;
    int     m_rr = 0;
    int     m_bc = 0;
    bit     m_err = 0;
    int     err_cnt = 0;

    logic [DW-1:0] log_data[$];
    logic          log_last[$];
    logic [IW-1:0] log_id[$];
    int            log_cyc[$];

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_id.delete();
        log_cyc.delete();
    endtask

    always @(negedge clk) begin
        mbeat_t        b;
        int            sz;
        int            c;
        bit            found;
        bit            err_n;
        bit            forced;
        logic [NS-1:0] exp_rdy;

        hs = s_tvalid & s_tready;
        if (!rstn) begin
            mq.delete();
            m_locked = 0; m_g = 0; m_rr = 0; m_bc = 0; m_err = 0;
            chk_eq("rst_m_tvalid", m_tvalid, 0);
            chk_eq("rst_s_tready", s_tready, 0);
            chk_eq("rst_grant_valid", grant_valid, 0);
            chk_eq("rst_err", err_overlong, 0);
        end else begin
            // compare DUT against the model's view of this cycle
            exp_rdy = '0;
            if (m_locked && mq.size() < 2) exp_rdy[m_g] = 1'b1;
            chk_eq("m_tvalid", m_tvalid, mq.size() != 0);
            if (mq.size() != 0) chk_eq("m_beat", {m_tlast, m_tdata, m_tstrb, m_tid}, mq[0]);
            chk_eq("s_tready", s_tready, exp_rdy);
            chk_eq("grant_valid", grant_valid, m_locked);
            if (m_locked) chk_eq("grant_idx", grant_idx, m_g);
            chk_eq("err_overlong", err_overlong, m_err);

            if (err_overlong) err_cnt++;
            if (m_tvalid && m_tready) begin
                log_data.push_back(m_tdata);
                log_last.push_back(m_tlast);
                log_id.push_back(m_tid);
                log_cyc.push_back(cyc);
            end

            // what the next clock edge must do
            sz = mq.size();
            err_n = 0;
            if (sz != 0 && m_tready) void'(mq.pop_front());
            if (m_locked) begin
                if (s_tvalid[m_g] && sz < 2) begin
                    forced = (m_bc == MAXB - 1);
                    b.data = s_tdata[m_g*DW +: DW];
                    b.strb = s_tstrb[m_g*SW +: SW];
                    b.id   = (s_tid[m_g*IW +: IW] & 8'hFC) | 8'(m_g);
                    b.last = s_tlast[m_g] || forced;
                    mq.push_back(b);
                    err_n = forced && !s_tlast[m_g];
                    if (b.last) begin
                        m_locked = 0;
                        m_rr = (m_g + 1) % NS;
                    end else begin
                        m_bc++;
                    end
                end
            end else if (s_tvalid != 0 && sz < 2) begin
                found = 0;
                for (int k = 0; k < NS; k++) begin
                    c = (m_rr + k) % NS;
                    if (!found && s_tvalid[c]) begin
                        m_g = c;
                        found = 1;
                    end
                end
                m_locked = 1;
                m_bc = 0;
            end
            m_err = err_n;
        end
    end

    // ---------------- directed and random sequences ----------------
    initial begin
        int t0;
        int guard;
        clear_src();
        #2 rstn = 1'b0;
        repeat (3) step();
        chk_eq("reset_m_tdata", m_tdata, 0);
        chk_eq("reset_m_tid", m_tid, 0);
        chk_eq("reset_m_tlast", m_tlast, 0);
        chk_eq("reset_grant_idx", grant_idx, 0);
        rstn = 1'b1;
        step();

        // single source: 3 beats from src1
        vprob = 100; mt_mode = 1; clear_log();
        add_pkt(1, 3, 8'h10, 32'hA0);
        step(); t0 = cyc;
        repeat (2) step();
        chk_eq("t1_grant_valid", grant_valid, 1);
        chk_eq("t1_grant_idx", grant_idx, 1);
        repeat (6) step();
        chk_eq("t1_nbeats", log_data.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk_eq("t1_data", log_data[k], 32'hA0 + k);
            chk_eq("t1_last", log_last[k], k == 2);
        end
        chk_eq("t1_tid", log_id[0], 8'h11);
        chk_eq("t1_first_lat", log_cyc[0] - t0, 2);
        chk_eq("t1_back_to_back", log_cyc[2] - log_cyc[0], 2);

        // rr_ptr now 2: src2 must beat src0
        clear_log();
        add_pkt(0, 1, 8'h00, 32'hB0);
        add_pkt(2, 1, 8'h00, 32'hB2);
        repeat (9) step();
        chk_eq("t1_rr_first", log_data[0], 32'hB2);
        chk_eq("t1_rr_second", log_data[1], 32'hB0);

        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;

        // all four sources, two 2-beat packets each
        clear_log();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++)
                add_pkt(s, 2, 8'(s << 4), 32'hC000_0000 + 32'(s * 256) + 32'(p * 16));
        repeat (40) step();
        chk_eq("t2_nbeats", log_data.size(), 16);
        for (int k = 0; k < 8; k++) begin
            chk_eq("t2_src_order", log_data[2*k][15:8], k % NS);
            chk_eq("t2_no_interleave", log_data[2*k+1], log_data[2*k] + 1);
            chk_eq("t2_last", {log_last[2*k], log_last[2*k+1]}, 2'b01);
            if (k > 0) chk_eq("t2_bubble", log_cyc[2*k] - log_cyc[2*k-1], 2);
        end

        // downstream stall mid-packet
        clear_log();
        add_pkt(0, 4, 8'h00, 32'hD0);
        step(); t0 = cyc;
        step();
        mt_mode = 0;
        step();
        step();
        chk_eq("t3_s_tready_drop", s_tready, 0);
        for (int k = 0; k < 3; k++) begin
            chk_eq("t3_hold_valid", m_tvalid, 1);
            chk_eq("t3_hold_data", m_tdata, 32'hD0);
            step();
        end
        mt_mode = 1;
        repeat (10) step();
        chk_eq("t3_nbeats", log_data.size(), 4);
        for (int k = 0; k < 4; k++) chk_eq("t3_data", log_data[k], 32'hD0 + k);

        // watchdog: 6-beat packet with MAX_BEATS=4
        clear_log(); err_cnt = 0;
        add_pkt(2, 6, 8'h20, 32'hE0);
        repeat (20) step();
        chk_eq("t4_nbeats", log_data.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk_eq("t4_data", log_data[k], 32'hE0 + k);
            chk_eq("t4_last", log_last[k], (k == 3) || (k == 5));
        end
        chk_eq("t4_err_pulses", err_cnt, 1);
        chk_eq("t4_rearb_gap", log_cyc[4] - log_cyc[3], 2);

        // tid tagging
        clear_log();
        add_pkt(3, 1, 8'hF0, 32'hF00D);
        repeat (7) step();
        chk_eq("t5_tid", log_id[0], 8'hF3);

        // reset during a packet
        mt_mode = 0;
        add_pkt(2, 4, 8'h00, 32'h60);
        repeat (3) step();
        #1 rstn = 1'b0;
        #1;
        chk_eq("t6_m_tvalid", m_tvalid, 0);
        chk_eq("t6_s_tready", s_tready, 0);
        chk_eq("t6_grant_valid", grant_valid, 0);
        clear_src();
        repeat (2) step();
        rstn = 1'b1;
        mt_mode = 1; clear_log();
        add_pkt(3, 1, 8'h00, 32'h73);
        add_pkt(0, 1, 8'h00, 32'h70);
        repeat (9) step();
        chk_eq("t6_nbeats", log_data.size(), 2);
        chk_eq("t6_first_src0", log_data[0], 32'h70);
        chk_eq("t6_second_src3", log_data[1], 32'h73);

        // randomized traffic with random backpressure and tvalid gaps
        vprob = 70; mt_mode = 2;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(99) < 25) begin
                int s;
                s = int'($urandom_range(NS - 1));
                if (slen[s] < SCAP - 8)
                    add_pkt(s, int'($urandom_range(6, 1)), 8'($urandom), $urandom);
            end
            step();
        end

        // drain
        mt_mode = 1;
        guard = 0;
        while (guard < 3000 && (m_tvalid || grant_valid || s_tvalid != 0 ||
               slen[0] != 0 || slen[1] != 0 || slen[2] != 0 || slen[3] != 0)) begin
            step();
            guard++;
        end
        chk_eq("drain_done", guard < 3000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
